// File: rtl/icache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
// Address layout: {tag, index, word offset, byte offset}.
package icache_pkg;

  localparam int ADDR_W          = 10;
  localparam int INDEX_W         = 3;
  localparam int BLOCK_BYTES     = 16;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int OFFSET_W        = 4;
  localparam int TAG_W           = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BLK_ADDR_W      = ADDR_W - OFFSET_W;
  localparam int NUM_BLOCKS      = 1 << INDEX_W;
  localparam int BLOCK_W         = BLOCK_BYTES * 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_READ = 2'd1,
    ST_UPDATE   = 2'd2
  } state_e;

  // Word w of a block lives at bits [32w+31:32w].
  function automatic logic [31:0] word_sel(input logic [BLOCK_W-1:0] blk,
                                           input logic [1:0] off);
    return blk[{off, 5'd0} +: 32];
  endfunction

endpackage

// File: rtl/icache_if.sv
// Bus bundles for the instruction cache: CPU fetch port and block-memory port.
// On each bus the master is the requester.
interface icache_cpu_if;
  logic [icache_pkg::ADDR_W-1:0] ADDRESS;
  logic [31:0]                   INSTRUCTION;
  logic                          BUSYWAIT;

  modport master (output ADDRESS, input INSTRUCTION, input BUSYWAIT);
  modport slave  (input ADDRESS, output INSTRUCTION, output BUSYWAIT);
endinterface

interface icache_mem_if;
  logic                              MEM_READ;
  logic [icache_pkg::BLK_ADDR_W-1:0] MEM_ADDRESS;
  logic [icache_pkg::BLOCK_W-1:0]    MEM_READDATA;
  logic                              MEM_BUSYWAIT;

  modport master (output MEM_READ, output MEM_ADDRESS,
                  input MEM_READDATA, input MEM_BUSYWAIT);
  modport slave  (input MEM_READ, input MEM_ADDRESS,
                  output MEM_READDATA, output MEM_BUSYWAIT);
endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: combinational read port,
// synchronous single-block write port, synchronous clear of all valid bits.
module icache_array
  import icache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLOCK_W-1:0] wr_data
);

  logic [NUM_BLOCKS-1:0] valid_r;
  logic [TAG_W-1:0]      tag_r  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data_r [NUM_BLOCKS];

  // Valid bits: cleared by reset, set when a block is filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_index] <= 1'b1;
    end
  end

  // Tag and data contents only matter once the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_r[wr_index]  <= wr_tag;
      data_r[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_r[rd_index];
  assign rd_tag   = tag_r[rd_index];
  assign rd_data  = data_r[rd_index];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller: same-cycle hits, block
// fill on miss. Define ICACHE_STATS_EN to add saturating HIT_COUNT/MISS_COUNT.
module icache_ctrl
  import icache_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  icache_cpu_if.slave  cpu,
  icache_mem_if.master mem
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]  HIT_COUNT,
  output logic [15:0]  MISS_COUNT
`endif
);

  state_e              state_r;
  state_e              state_next_s;
  logic [BLK_ADDR_W-1:0] blk_addr_r;
  logic [BLOCK_W-1:0]  fill_data_r;

  logic [TAG_W-1:0]    req_tag_s;
  logic [INDEX_W-1:0]  req_index_s;
  logic [1:0]          req_offset_s;
  logic                arr_valid_s;
  logic [TAG_W-1:0]    arr_tag_s;
  logic [BLOCK_W-1:0]  arr_data_s;
  logic                hit_s;
  logic                wr_en_s;
  logic                unused_s;

  assign req_tag_s    = cpu.ADDRESS[ADDR_W-1 -: TAG_W];
  assign req_index_s  = cpu.ADDRESS[OFFSET_W +: INDEX_W];
  assign req_offset_s = cpu.ADDRESS[3:2];
  assign unused_s     = ^cpu.ADDRESS[1:0];

  assign hit_s   = arr_valid_s && (arr_tag_s == req_tag_s);
  assign wr_en_s = (state_r == ST_UPDATE) && !RESET;

  icache_array u_array (
    .clk      (CLK),
    .rst      (RESET),
    .rd_index (req_index_s),
    .rd_valid (arr_valid_s),
    .rd_tag   (arr_tag_s),
    .rd_data  (arr_data_s),
    .wr_en    (wr_en_s),
    .wr_index (blk_addr_r[INDEX_W-1:0]),
    .wr_tag   (blk_addr_r[BLK_ADDR_W-1:INDEX_W]),
    .wr_data  (fill_data_r)
  );

  // State register; reset abandons any fill in progress.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!hit_s) state_next_s = ST_MEM_READ;
        else        state_next_s = ST_IDLE;
      end
      ST_MEM_READ: begin
        if (!mem.MEM_BUSYWAIT) state_next_s = ST_UPDATE;
        else                   state_next_s = ST_MEM_READ;
      end
      ST_UPDATE: state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Block address is captured once per miss so a wandering ADDRESS cannot redirect the fill.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      blk_addr_r <= '0;
    end else if ((state_r == ST_IDLE) && !hit_s) begin
      blk_addr_r <= {req_tag_s, req_index_s};
    end
  end

  // Memory data is only valid in the cycle MEM_BUSYWAIT falls.
  always_ff @(posedge CLK) begin
    if ((state_r == ST_MEM_READ) && !mem.MEM_BUSYWAIT) begin
      fill_data_r <= mem.MEM_READDATA;
    end
  end

  // CPU and memory-side outputs.
  always_comb begin
    cpu.BUSYWAIT    = 1'b0;
    cpu.INSTRUCTION = 32'h0;
    mem.MEM_READ    = 1'b0;
    mem.MEM_ADDRESS = '0;
    if (!RESET) begin
      cpu.BUSYWAIT = (state_r != ST_IDLE) || !hit_s;
      if (hit_s) cpu.INSTRUCTION = word_sel(arr_data_s, req_offset_s);
      else       cpu.INSTRUCTION = 32'h0;
    end else begin
      cpu.BUSYWAIT    = 1'b0;
      cpu.INSTRUCTION = 32'h0;
    end
    if (state_r == ST_MEM_READ) begin
      mem.MEM_READ    = 1'b1;
      mem.MEM_ADDRESS = blk_addr_r;
    end else begin
      mem.MEM_READ    = 1'b0;
      mem.MEM_ADDRESS = '0;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_r;
  logic [15:0] miss_cnt_r;

  // Saturating access counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_cnt_r  <= 16'h0;
      miss_cnt_r <= 16'h0;
    end else if (state_r == ST_IDLE) begin
      if (hit_s && (hit_cnt_r != 16'hFFFF))   hit_cnt_r  <= hit_cnt_r + 16'd1;
      if (!hit_s && (miss_cnt_r != 16'hFFFF)) miss_cnt_r <= miss_cnt_r + 16'd1;
    end
  end

  assign HIT_COUNT  = hit_cnt_r;
  assign MISS_COUNT = miss_cnt_r;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: inputs driven 3 ns after the rising edge,
// outputs sampled 1 ns later; block memory is modelled inside run_fill.
module tb_icache_ctrl;

  logic CLK;
  logic RESET;
  int   checks;
  int   errors;

  icache_cpu_if cpu_bus ();
  icache_mem_if mem_bus ();

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  icache_ctrl dut (
    .CLK   (CLK),
    .RESET (RESET),
    .cpu   (cpu_bus),
    .mem   (mem_bus)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT  (hit_count),
    .MISS_COUNT (miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [127:0] BLK0 = 128'h0000000F_0000000B_0A000003_08000001;
  localparam logic [127:0] BLK1 = 128'h11111114_11111113_11111112_11111111;
  localparam logic [127:0] BLK2 = 128'h22222224_22222223_22222222_22222221;
  localparam logic [127:0] BLK3 = 128'h3333000F_3333000B_33330007_33330003;

  int         fill_rd;
  int         fill_bw;
  int         fill_req;
  logic [5:0] fill_addr;
  logic       fill_first_bw;

  task automatic cyc();
    @(posedge CLK);
    #3;
  endtask

  // Called in the cycle the miss address is presented; serves exactly one block.
  task automatic run_fill(input int lat, input logic [127:0] blk);
    logic prev_rd;
    logic done;
    prev_rd = 1'b0;
    done = 1'b0;
    fill_rd = 0; fill_bw = 0; fill_req = 0; fill_addr = 6'h3F;
    #1;
    fill_first_bw = cpu_bus.BUSYWAIT;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) begin
        @(posedge CLK);
        #4;
      end
      if (!cpu_bus.BUSYWAIT) begin
        done = 1'b1;
        break;
      end
      fill_bw++;
      if (mem_bus.MEM_READ) begin
        if (!prev_rd) begin
          fill_req++;
          fill_addr = mem_bus.MEM_ADDRESS;
        end
        fill_rd++;
        if (fill_rd > lat) begin
          mem_bus.MEM_BUSYWAIT = 1'b0;
          mem_bus.MEM_READDATA = blk;
        end else begin
          mem_bus.MEM_BUSYWAIT = 1'b1;
        end
      end else begin
        mem_bus.MEM_BUSYWAIT = 1'b1;
      end
      prev_rd = mem_bus.MEM_READ;
    end
    mem_bus.MEM_BUSYWAIT = 1'b1;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL fill_timeout: got done=%b expected 1", done); end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    cpu_bus.ADDRESS = 10'h000;
    cyc(); cyc();
    #1;
    checks++; if (cpu_bus.BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_busywait: got %b expected 0", cpu_bus.BUSYWAIT); end
    checks++; if (cpu_bus.INSTRUCTION !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 00000000", cpu_bus.INSTRUCTION); end
    checks++; if (mem_bus.MEM_READ !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b expected 0", mem_bus.MEM_READ); end
    checks++; if (mem_bus.MEM_ADDRESS !== 6'h00) begin errors++; $display("FAIL reset_mem_addr: got %h expected 00", mem_bus.MEM_ADDRESS); end
  endtask

  task automatic test_cold_miss();
    cyc();
    RESET = 1'b0;
    cpu_bus.ADDRESS = 10'h000;
    run_fill(5, BLK0);
    checks++; if (fill_first_bw !== 1'b1) begin errors++; $display("FAIL cold_busywait_now: got %b expected 1", fill_first_bw); end
    checks++; if (fill_addr !== 6'h00) begin errors++; $display("FAIL cold_mem_addr: got %h expected 00", fill_addr); end
    checks++; if (fill_req !== 1) begin errors++; $display("FAIL cold_req_count: got %0d expected 1", fill_req); end
    checks++; if (fill_rd !== 6) begin errors++; $display("FAIL cold_mem_read_cycles: got %0d expected 6", fill_rd); end
    checks++; if (fill_bw !== 8) begin errors++; $display("FAIL cold_busywait_cycles: got %0d expected 8", fill_bw); end
    checks++; if (cpu_bus.INSTRUCTION !== 32'h08000001) begin errors++; $display("FAIL cold_instr: got %h expected 08000001", cpu_bus.INSTRUCTION); end
  endtask

  task automatic test_spatial_hit();
    logic [9:0]  addrs [3] = '{10'h004, 10'h008, 10'h00C};
    logic [31:0] words [3] = '{32'h0A000003, 32'h0000000B, 32'h0000000F};
    for (int i = 0; i < 3; i++) begin
      cyc();
      cpu_bus.ADDRESS = addrs[i];
      #1;
      checks++; if (cpu_bus.INSTRUCTION !== words[i]) begin errors++; $display("FAIL spatial_instr[%0d]: got %h expected %h", i, cpu_bus.INSTRUCTION, words[i]); end
      checks++; if (cpu_bus.BUSYWAIT !== 1'b0) begin errors++; $display("FAIL spatial_busywait[%0d]: got %b expected 0", i, cpu_bus.BUSYWAIT); end
      checks++; if (mem_bus.MEM_READ !== 1'b0) begin errors++; $display("FAIL spatial_mem_read[%0d]: got %b expected 0", i, mem_bus.MEM_READ); end
    end
  endtask

  task automatic test_conflict();
    cyc();
    cpu_bus.ADDRESS = 10'h080;
    run_fill(2, BLK1);
    checks++; if (fill_first_bw !== 1'b1) begin errors++; $display("FAIL conflict_miss: got %b expected 1", fill_first_bw); end
    checks++; if (fill_addr !== 6'h08) begin errors++; $display("FAIL conflict_mem_addr: got %h expected 08", fill_addr); end
    checks++; if (cpu_bus.INSTRUCTION !== 32'h11111111) begin errors++; $display("FAIL conflict_instr: got %h expected 11111111", cpu_bus.INSTRUCTION); end
    cyc();
    cpu_bus.ADDRESS = 10'h000;
    run_fill(1, BLK0);
    checks++; if (fill_first_bw !== 1'b1) begin errors++; $display("FAIL evicted_miss: got %b expected 1", fill_first_bw); end
    checks++; if (fill_addr !== 6'h00) begin errors++; $display("FAIL evicted_mem_addr: got %h expected 00", fill_addr); end
    checks++; if (cpu_bus.INSTRUCTION !== 32'h08000001) begin errors++; $display("FAIL evicted_instr: got %h expected 08000001", cpu_bus.INSTRUCTION); end
  endtask

  task automatic test_reset_mid_fill();
    cyc();
    cpu_bus.ADDRESS = 10'h010;
    #1;
    checks++; if (cpu_bus.BUSYWAIT !== 1'b1) begin errors++; $display("FAIL midrst_miss: got %b expected 1", cpu_bus.BUSYWAIT); end
    cyc();
    #1;
    checks++; if (mem_bus.MEM_READ !== 1'b1) begin errors++; $display("FAIL midrst_req: got %b expected 1", mem_bus.MEM_READ); end
    checks++; if (mem_bus.MEM_ADDRESS !== 6'h01) begin errors++; $display("FAIL midrst_req_addr: got %h expected 01", mem_bus.MEM_ADDRESS); end
    RESET = 1'b1;
    cyc();
    #1;
    checks++; if (mem_bus.MEM_READ !== 1'b0) begin errors++; $display("FAIL midrst_drop: got %b expected 0", mem_bus.MEM_READ); end
    RESET = 1'b0;
    #1;
    checks++; if (cpu_bus.BUSYWAIT !== 1'b1) begin errors++; $display("FAIL midrst_remiss: got %b expected 1", cpu_bus.BUSYWAIT); end
    run_fill(1, BLK2);
    checks++; if (fill_addr !== 6'h01) begin errors++; $display("FAIL midrst_refill_addr: got %h expected 01", fill_addr); end
    checks++; if (cpu_bus.INSTRUCTION !== 32'h22222221) begin errors++; $display("FAIL midrst_instr: got %h expected 22222221", cpu_bus.INSTRUCTION); end
  endtask

  task automatic test_stall_hold();
    cyc();
    cpu_bus.ADDRESS = 10'h028;
    run_fill(40, BLK3);
    checks++; if (fill_rd !== 41) begin errors++; $display("FAIL stall_mem_read_cycles: got %0d expected 41", fill_rd); end
    checks++; if (fill_bw !== 43) begin errors++; $display("FAIL stall_busywait_cycles: got %0d expected 43", fill_bw); end
    checks++; if (fill_req !== 1) begin errors++; $display("FAIL stall_req_count: got %0d expected 1", fill_req); end
    checks++; if (fill_addr !== 6'h02) begin errors++; $display("FAIL stall_mem_addr: got %h expected 02", fill_addr); end
    checks++; if (cpu_bus.INSTRUCTION !== 32'h3333000B) begin errors++; $display("FAIL stall_instr: got %h expected 3333000B", cpu_bus.INSTRUCTION); end
  endtask

  task automatic test_idle_mem_busywait();
    cyc();
    mem_bus.MEM_BUSYWAIT = 1'b0;
    cpu_bus.ADDRESS = 10'h02C;
    #1;
    checks++; if (cpu_bus.INSTRUCTION !== 32'h3333000F) begin errors++; $display("FAIL idlebw_instr: got %h expected 3333000F", cpu_bus.INSTRUCTION); end
    checks++; if (cpu_bus.BUSYWAIT !== 1'b0) begin errors++; $display("FAIL idlebw_busywait: got %b expected 0", cpu_bus.BUSYWAIT); end
    cyc();
    #1;
    checks++; if (mem_bus.MEM_READ !== 1'b0) begin errors++; $display("FAIL idlebw_mem_read: got %b expected 0", mem_bus.MEM_READ); end
    mem_bus.MEM_BUSYWAIT = 1'b1;
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    cyc();
    RESET = 1'b1;
    cyc();
    #1;
    checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL stats_reset_hit: got %0d expected 0", hit_count); end
    checks++; if (miss_count !== 16'd0) begin errors++; $display("FAIL stats_reset_miss: got %0d expected 0", miss_count); end
    RESET = 1'b0;
    cpu_bus.ADDRESS = 10'h000;
    run_fill(1, BLK0);
    cpu_bus.ADDRESS = 10'h004;
    cyc();
    cpu_bus.ADDRESS = 10'h008;
    cyc();
    cpu_bus.ADDRESS = 10'h00C;
    cyc();
    cpu_bus.ADDRESS = 10'h080;
    run_fill(1, BLK1);
    cyc();
    #1;
    checks++; if (hit_count !== 16'd4) begin errors++; $display("FAIL stats_hit: got %0d expected 4", hit_count); end
    checks++; if (miss_count !== 16'd2) begin errors++; $display("FAIL stats_miss: got %0d expected 2", miss_count); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    RESET = 1'b1;
    cpu_bus.ADDRESS = 10'h000;
    mem_bus.MEM_BUSYWAIT = 1'b1;
    mem_bus.MEM_READDATA = 128'h0;
    test_reset();
    test_cold_miss();
    test_spatial_hit();
    test_conflict();
    test_reset_mid_fill();
    test_stall_hold();
    test_idle_mem_busywait();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch port (PC to INSTRUCTION) and the 128-bit-wide instruction memory.
- Replaces the bench's combinational fetch path.
- Hits return the instruction in the same cycle. Misses stall the CPU through BUSYWAIT while one 16-byte block is fetched.
- Shares the CPU stall semantics already used by the data cache.

Parameters:
- ADDR_W, 10, byte-address width used from PC (1 KB instruction space).
- INDEX_W, 3, index bits (2^INDEX_W blocks). TAG_W = ADDR_W-INDEX_W-4.

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  synchronous, active-high; clears all valid bits and the FSM
- ADDRESS  in  ADDR_W  byte address (PC[ADDR_W-1:0]); bits [1:0] ignored
- INSTRUCTION  out  32  fetched instruction word
- BUSYWAIT  out  1  CPU stall request
- MEM_READ  out  1  block read request to instruction memory
- MEM_ADDRESS  out  ADDR_W-4  block address {tag,index}
- MEM_READDATA  in  128  block data; word w at bits [32w+31:32w]
- MEM_BUSYWAIT  in  1  memory busy; data valid in the cycle it falls after a request

Behaviour:
- Address split: offset = ADDRESS[3:2], index = ADDRESS[3+INDEX_W:4], tag = upper TAG_W bits.
- Storage per block: valid bit, TAG_W tag, 128-bit data.
- Hit: valid[index] && tag match.
  - Combinational. INSTRUCTION = data[index] word[offset] in the same cycle. BUSYWAIT=0.
- Miss: BUSYWAIT=1 combinationally, in the same cycle ADDRESS is presented.
- FSM states: IDLE, MEM_READ, UPDATE.
  - IDLE: on miss (and RESET low), go to MEM_READ at the next edge and latch {tag,index}.
  - MEM_READ: MEM_READ=1 and MEM_ADDRESS = latched block address. Hold until a cycle with MEM_BUSYWAIT=0, then go to UPDATE.
  - UPDATE: one cycle. Write MEM_READDATA (registered on MEM_READ exit) into data[index], set tag and valid, return to IDLE. BUSYWAIT stays 1 through UPDATE. The following cycle is a hit.
- Miss penalty: memory latency + 2 cycles.
- Reset values (held while RESET=1):
  - MEM_READ=0, MEM_ADDRESS=0, BUSYWAIT=0, INSTRUCTION=32'h0.
  - FSM=IDLE, all valid=0.
  - Data and tag arrays need not be cleared.
- Reset mid-miss: the fill is abandoned at the next edge and the block is not marked valid. MEM_READ drops on that edge.
- ADDRESS is required stable while BUSYWAIT=1.
  - If it changes anyway, the fill completes for the latched address.
  - Hit/miss is then re-evaluated for the new address in IDLE.
- Out-of-range addresses (bits above ADDR_W) are ignored (aliasing).
- MEM_BUSYWAIT high while IDLE is ignored.
- No write path and no dirty bits.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Extra outputs HIT_COUNT[15:0] and MISS_COUNT[15:0], both cleared by RESET.
  - HIT_COUNT increments once per CLK edge where FSM=IDLE, RESET=0 and the access hits.
  - MISS_COUNT increments once per IDLE to MEM_READ transition.
  - Both saturate at 16'hFFFF.
- Undefined: ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package icache_pkg:
  - state encoding (IDLE=2'd0, MEM_READ=2'd1, UPDATE=2'd2)
  - BLOCK_BYTES=16, WORDS_PER_BLOCK=4
  - field-width localparams derived from ADDR_W/INDEX_W
- One natural sub-module, icache_array: valid/tag/data storage with a combinational read port and a synchronous write/clear port.
- FSM and hit logic stay in icache_ctrl.

Test Plan:
- Cold miss: RESET pulse, ADDRESS=10'h000, memory returns block 128'h0000000F_0000000B_0A000003_08000001 after 5 cycles.
  - BUSYWAIT=1 immediately.
  - MEM_READ=1 with MEM_ADDRESS=6'h00 until MEM_BUSYWAIT falls.
  - BUSYWAIT=0 after UPDATE, INSTRUCTION=32'h08000001.
- Spatial hit: after the fill, ADDRESS=10'h004, 008, 00C.
  - INSTRUCTION=32'h0A000003, 0000000B, 0000000F in consecutive cycles.
  - BUSYWAIT stays 0 and MEM_READ stays 0.
- Conflict eviction: ADDRESS=10'h080 (same index 0, tag 1).
  - Miss with MEM_ADDRESS=6'h08.
  - Then 10'h000 misses again (tag 0 evicted). MEM_ADDRESS=6'h00.
- Reset mid-fill: assert RESET while in MEM_READ.
  - MEM_READ=0 next edge.
  - After release, the same address misses again (valid not set).
- Stall holding: MEM_BUSYWAIT held high 40 cycles.
  - BUSYWAIT=1 and MEM_READ=1 for all 40 cycles plus UPDATE.
  - No second request is issued.
- With ICACHE_STATS_EN: the sequence miss, 3 hits, miss, hit ends with HIT_COUNT=4 and MISS_COUNT=2.
